// File: rtl/keypad_debounce_scan.sv
// Keypad front end: 2-flop synchroniser, debounce to a stable vector, single-key
// press detection with optional auto-repeat, registered one-hot and binary key codes.
module keypad_debounce_scan #(
    parameter int unsigned NUM_KEYS        = 12,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_RATE     = 8,
    parameter int unsigned IDX_W           = $clog2(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] Keypad_in,
    input  logic                repeat_en,
    output logic                valid,
    output logic [NUM_KEYS-1:0] Scan_out,
    output logic [IDX_W-1:0]    key_idx,
    output logic                multi
);
    localparam int unsigned N_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned R_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned R_W   = $clog2(R_MAX) + 1;
    localparam int unsigned P_W   = $clog2(NUM_KEYS + 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] sync2_q, sync2_d;
    logic [NUM_KEYS-1:0] cand_q, cand_d;
    logic [N_W-1:0]      cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] stab_q, stab_d;
    state_t              state_q, state_d;
    logic [R_W-1:0]      rpt_q, rpt_d;
    logic                valid_q, valid_d;
    logic [NUM_KEYS-1:0] scan_q, scan_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                multi_q, multi_d;

    logic [P_W-1:0]      pop_c;
    logic [IDX_W-1:0]    idx_c;
    logic                single_c;
    logic [R_W-1:0]      rpt_lim_c;

    // Synchroniser and debounce: stable vector only moves after an unbroken run
    always_comb begin
        sync1_d = Keypad_in;
        sync2_d = sync1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        stab_d  = stab_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q < N_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d = cnt_q + N_W'(1);
        end else begin
            stab_d = cand_q;
        end
    end

    // Decode the next stable vector so the press registers in the same edge it settles
    always_comb begin
        pop_c = '0;
        idx_c = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            pop_c = pop_c + P_W'(stab_d[i]);
            if (stab_d[i]) begin
                idx_c = IDX_W'(i);
            end
        end
    end

    assign single_c  = (pop_c == P_W'(1));
    assign rpt_lim_c = (state_q == HOLD) ? R_W'(REPEAT_DELAY - 1) : R_W'(REPEAT_RATE - 1);

    // Press / hold / repeat control; a change of the held vector always wins over a repeat
    always_comb begin
        state_d = state_q;
        rpt_d   = rpt_q;
        valid_d = 1'b0;
        scan_d  = scan_q;
        idx_d   = idx_q;
        multi_d = (pop_c > P_W'(1));
        case (state_q)
            IDLE: begin
                if (single_c) begin
                    valid_d = 1'b1;
                    scan_d  = stab_d;
                    idx_d   = idx_c;
                    rpt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (stab_d != scan_q) begin
                    state_d = IDLE;
                    scan_d  = '0;
                    idx_d   = '0;
                    rpt_d   = '0;
                end else if (repeat_en) begin
                    if (rpt_q == rpt_lim_c) begin
                        valid_d = 1'b1;
                        rpt_d   = '0;
                        state_d = REPEAT;
                    end else begin
                        rpt_d = rpt_q + R_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                scan_d  = '0;
                idx_d   = '0;
                rpt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            stab_q  <= '0;
            state_q <= IDLE;
            rpt_q   <= '0;
            valid_q <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
            multi_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            stab_q  <= stab_d;
            state_q <= state_d;
            rpt_q   <= rpt_d;
            valid_q <= valid_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            multi_q <= multi_d;
        end
    end

    assign valid    = valid_q;
    assign Scan_out = scan_q;
    assign key_idx  = idx_q;
    assign multi    = multi_q;

endmodule
